div_controller: RTL and testbench
=================================

// Module: div_controller
// PURPOSE
//  Sequences a 1-bit/cycle restoring divider for DIV/DIVU and owns the HI/LO write.
//  Sits beside the Execute stage: accepts operands on start, runs WIDTH iterations, writes HI/LO.
//  Exports the divide-in-flight indication used to stall mfhi/mflo in Decode.
//  Replaces single-cycle combinational divide, so the hazard logic needs no HasDiv pipe flags.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count; counter is $clog2(WIDTH) bits
// PORTS
//  clock        in   1      single clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  start        in   1      Execute stage issues DIV/DIVU this cycle
//  is_signed    in   1      1 = DIV, 0 = DIVU; sampled with start
//  dividend     in   WIDTH  rs value; sampled with start
//  divisor      in   WIDTH  rt value; sampled with start
//  flush        in   1      cancel any divide in flight (trap/exception)
//  mf_op_d      in   1      mfhi/mflo in Decode
//  busy         out  1      divide in flight (ITER, FIX or DONE)
//  done         out  1      one-cycle result-valid pulse
//  hi_lo_we     out  1      HI/LO write enable; equal to done
//  hi_out       out  WIDTH  remainder -> HI
//  lo_out       out  WIDTH  quotient  -> LO
//  div_by_zero  out  1      pulses with done when divisor was 0
//  stall_mf     out  1      = mf_op_d && (busy || start); combinational
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and internal registers 0. Async; valid mid-divide, no write.
//  FSM: IDLE -> ITER -> FIX -> DONE -> IDLE.
//   IDLE: on start && !flush, latch |dividend|, |divisor| (magnitude only if is_signed),
//         sign_q = a[W-1]^b[W-1], sign_r = a[W-1] (0 if unsigned), zero = (divisor==0),
//         remainder acc=0, count=0 -> ITER.
//   ITER: per cycle shift {acc,q} left 1; if acc>=|divisor| then acc-=|divisor|, q[0]=1.
//         acc is WIDTH+1 bits internally, no overflow. After count==WIDTH-1 -> FIX.
//   FIX: quotient negated if sign_q, remainder negated if sign_r; result regs loaded -> DONE.
//         Divide-by-zero skips correction: lo_out=all ones, hi_out=original dividend.
//   DONE: done=hi_lo_we=1 for exactly this cycle -> IDLE.
//  Latency: start sampled at edge T; done high in the cycle after edge T+WIDTH+1 (WIDTH+2 cycles).
//  busy: high from the cycle after edge T through the DONE cycle inclusive.
//  hi_out/lo_out: hold the last result until the next FIX; unchanged by flush.
//  Start when not IDLE: ignored, no state disturbance. Decode must stall issue via stall_mf.
//  flush: synchronous, any state -> IDLE at next edge; no done/hi_lo_we.
//   Flush in DONE: the write in that same cycle still occurs.
//  flush && start in IDLE: flush wins; divide not accepted.
//  Signed overflow (0x80000000 / -1): lo_out=0x80000000, hi_out=0. No exception.
//  Remainder sign follows dividend; quotient truncates toward zero (MIPS semantics).
// TESTING
//  DIVU 100/7 -> lo=14, hi=2, done exactly WIDTH+2 cycles after start, busy low the cycle after.
//  DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
//  DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1.
//  flush at iteration 10 -> no hi_lo_we, busy=0 next cycle; new start then completes 9/3 -> lo=3, hi=0.
//  start pulsed again mid-divide -> ignored, first result intact.
//   mf_op_d held -> stall_mf=1 through DONE, 0 after.
//  reset_n low at iteration 5 -> outputs 0 immediately, no write; after release, IDLE accepts start.

Source files
------------

// File: rtl/div_controller.sv
`default_nettype none
// ============================================================================
// Module      : div_controller
// Description : Sequencer for a 1-bit/cycle restoring divider (DIV/DIVU).
//               Accepts operands on start, runs WIDTH iterations, applies the
//               sign correction, then pulses the HI/LO write. Also exports the
//               divide-in-flight stall for mfhi/mflo in Decode.
// Revision    : 1.0 - initial release
// ============================================================================
module div_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  input  logic             mf_op_d,
  output logic             busy,
  output logic             done,
  output logic             hi_lo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero,
  output logic             stall_mf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;          // partial remainder (always < divisor)
  logic [WIDTH-1:0] quo_q, quo_d;          // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dsr_q, dsr_d;          // divisor magnitude
  logic [CW-1:0]    count_q, count_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted;               // WIDTH+1 bits so the compare never overflows

  // Next-state, datapath step and result correction.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    count_d   = count_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mag_a     = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_b     = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    shifted   = {acc_q, quo_q[WIDTH-1]};

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          quo_d     = mag_a;
          dsr_d     = mag_b;
          neg_quo_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = is_signed && dividend[WIDTH-1];
          zero_d    = (divisor == '0);
          acc_d     = '0;
          count_d   = '0;
          state_d   = S_ITER;
        end
      end
      S_ITER: begin
        if (shifted >= {1'b0, dsr_q}) begin
          acc_d = WIDTH'(shifted - {1'b0, dsr_q});
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == C_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        // With a zero divisor every step subtracts 0, so the remainder is
        // |dividend| and the sign fix below restores the original dividend.
        lo_d    = zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
        hi_d    = neg_rem_q ? -acc_q : acc_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush aborts from any state and never disturbs the held result.
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      count_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      count_q   <= count_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign hi_lo_we    = done;
  assign div_by_zero = done && zero_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign stall_mf    = mf_op_d && (busy || start);

endmodule
`default_nettype wire

// File: tb/tb_div_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_controller
// Description : Directed, table-driven bench for div_controller plus
//               hand-written flush / restart / reset / stall sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_controller;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             is_signed = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             flush = 1'b0;
  logic             mf_op_d = 1'b0;
  logic             busy, done, hi_lo_we, div_by_zero, stall_mf;
  logic [WIDTH-1:0] hi_out, lo_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  div_controller #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .flush(flush), .mf_op_d(mf_op_d),
    .busy(busy), .done(done), .hi_lo_we(hi_lo_we), .hi_out(hi_out),
    .lo_out(lo_out), .div_by_zero(div_by_zero), .stall_mf(stall_mf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one divide and follow it to completion. mid>0 pulses a second
  // start that many edges into the divide, which must be ignored.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi,
                         input logic edbz, input int mid);
    int k;
    @(negedge clock);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clock); #1;
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    k = 0;
    while (!done && k < 200) begin
      if (mf_op_d) chk("stall_mf_busy", {31'b0, stall_mf}, 32'd1);
      chk("no_early_we", {31'b0, hi_lo_we}, 32'd0);
      @(posedge clock); #1;
      k++;
      if (k == mid) begin
        start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
        @(posedge clock); #1;
        start = 1'b0;
        k++;
      end
    end
    chk("latency", k, WIDTH + 1);
    chk("lo_out", lo_out, elo);
    chk("hi_out", hi_out, ehi);
    chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, edbz});
    chk("hi_lo_we", {31'b0, hi_lo_we}, 32'd1);
    if (mf_op_d) chk("stall_mf_done", {31'b0, stall_mf}, 32'd1);
    @(posedge clock); #1;
    chk("busy_after_done", {31'b0, busy}, 32'd0);
    chk("we_after_done", {31'b0, hi_lo_we}, 32'd0);
    chk("lo_held", lo_out, elo);
    if (mf_op_d) chk("stall_mf_after", {31'b0, stall_mf}, 32'd0);
    last_lo = elo;
    last_hi = ehi;
  endtask

  initial begin
    logic we_seen;
    int   k;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,         32'd2,          1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,          1'b0};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,          1'b0};
    vecs[4] = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FFF8,  32'd0,        32'hFFFF_FFFF,  32'hFFFF_FFF8,  1'b1};
    vecs[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000,  1'b0};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Table-driven divides
    for (int i = 0; i < 8; i++)
      run_div(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].dbz, 0);

    // Flush at iteration 10: no write, result untouched, then a fresh divide
    @(negedge clock);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    we_seen = 1'b0;
    repeat (10) begin
      @(posedge clock); #1;
      if (hi_lo_we) we_seen = 1'b1;
    end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    repeat (WIDTH) begin
      @(posedge clock); #1;
      if (hi_lo_we) we_seen = 1'b1;
    end
    chk("flush_no_we", {31'b0, we_seen}, 32'd0);
    chk("flush_lo_held", lo_out, last_lo);
    chk("flush_hi_held", hi_out, last_hi);
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);

    // Second start mid-divide is ignored; mf_op_d held shows the stall
    mf_op_d = 1'b1;
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 5);
    mf_op_d = 1'b0;

    // flush && start in IDLE: flush wins; stall_mf is combinational on start
    @(negedge clock);
    mf_op_d = 1'b1; start = 1'b1; flush = 1'b1; dividend = 32'd77; divisor = 32'd7;
    #1;
    chk("stall_mf_start", {31'b0, stall_mf}, 32'd1);
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0; mf_op_d = 1'b0;
    chk("flush_start_busy", {31'b0, busy}, 32'd0);
    chk("flush_start_lo", lo_out, last_lo);

    // Flush during DONE: the write in that cycle still happens
    @(negedge clock);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd20; divisor = 32'd6;
    @(posedge clock); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    flush = 1'b1;
    #1;
    chk("flushdone_we", {31'b0, hi_lo_we}, 32'd1);
    chk("flushdone_lo", lo_out, 32'd3);
    chk("flushdone_hi", hi_out, 32'd2);
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flushdone_busy", {31'b0, busy}, 32'd0);
    chk("flushdone_lo_held", lo_out, 32'd3);

    // Asynchronous reset at iteration 5
    @(negedge clock);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_we", {31'b0, hi_lo_we}, 32'd0);
    chk("arst_lo", lo_out, 32'd0);
    chk("arst_hi", hi_out, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
